// File: rtl/uart_regif_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_regif_core
// Brief    : Memory-mapped 8N1 UART with baud divider and a single-byte RX
//            holding register. Define UART_HW_FLOW_CTRL_EN for RTS/CTS gating.
// Revision : 1.0
// ============================================================================
module uart_regif_core #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic [ADDR_W-1:0] address,
    input  logic              write,
    input  logic              read,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              txd,
    input  logic              rxd,
    output logic              rts,
    input  logic              cts
);

    localparam logic [ADDR_W-1:0] c_addr_write_wait = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] c_addr_div        = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_addr_data       = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] c_addr_soft_reset = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] c_addr_read_valid = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] c_addr_rxen       = ADDR_W'(5);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    logic [DIV_W-1:0]  r_div;
    logic              r_rxen;
    logic              r_soft_rst;
    logic              r_rx_valid;
    logic [7:0]        r_rx_byte;

    logic [1:0]        r_tx_state;
    logic [1:0]        w_tx_state_nxt;
    logic [DIV_W-1:0]  r_tx_cnt;
    logic [2:0]        r_tx_bit;
    logic [7:0]        r_tx_shift;
    logic              r_write_wait;
    logic              w_txd;

    logic [1:0]        r_rx_state;
    logic [1:0]        w_rx_state_nxt;
    logic [DIV_W-1:0]  r_rx_cnt;
    logic [2:0]        r_rx_bit;
    logic [7:0]        r_rx_shift;
    logic [2:0]        r_rx_sync;

    logic              w_wr;
    logic              w_rd;
    logic              w_data_wr;
    logic              w_data_rd;
    logic              w_cts_ok;
    logic              w_tx_accept;
    logic              w_tx_go;
    logic [DIV_W:0]    w_div_ext;
    logic [DIV_W:0]    w_half_ext;
    logic [DIV_W:0]    w_tx_cnt_inc;
    logic [DIV_W:0]    w_rx_cnt_inc;
    logic              w_tx_bit_end;
    logic              w_rx_bit_end;
    logic              w_rx_half_end;
    logic              w_rx_fall;
    logic              w_rx_done;
    logic              w_rx_cnt_clr;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_unused_bits;

    assign w_wr      = sel & write;
    assign w_rd      = sel & read;
    assign w_data_wr = w_wr & (address == c_addr_data);
    assign w_data_rd = w_rd & (address == c_addr_data);
    assign w_unused_bits = ^data_in[DATA_W-1:DIV_W];

`ifdef UART_HW_FLOW_CTRL_EN
    assign w_cts_ok = cts;
    assign rts      = r_rxen & ~r_rx_valid & ~r_soft_rst;
`else
    // Without flow control the peer's cts has no effect on transmission.
    assign w_cts_ok = cts | 1'b1;
    assign rts      = r_rxen & ~r_soft_rst;
`endif

    // Bit timers compare count+1 against the divider so div of 0 or 1 still advances.
    assign w_div_ext     = {1'b0, r_div};
    assign w_half_ext    = {2'b00, r_div[DIV_W-1:1]};
    assign w_tx_cnt_inc  = {1'b0, r_tx_cnt} + {{DIV_W{1'b0}}, 1'b1};
    assign w_rx_cnt_inc  = {1'b0, r_rx_cnt} + {{DIV_W{1'b0}}, 1'b1};
    assign w_tx_bit_end  = (w_tx_cnt_inc >= w_div_ext);
    assign w_rx_bit_end  = (w_rx_cnt_inc >= w_div_ext);
    assign w_rx_half_end = (w_rx_cnt_inc >= w_half_ext);

    assign w_tx_accept = w_data_wr & ~r_write_wait & ~r_soft_rst & (r_tx_state == c_st_idle);
    assign w_tx_go     = (w_tx_accept | r_write_wait) & w_cts_ok;

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_txd          = 1'b1;
        case (r_tx_state)
            c_st_idle:  if (w_tx_go) w_tx_state_nxt = c_st_start;
            c_st_start: begin
                w_txd = 1'b0;
                if (w_tx_bit_end) w_tx_state_nxt = c_st_data;
            end
            c_st_data: begin
                w_txd = r_tx_shift[0];
                if (w_tx_bit_end && (r_tx_bit == 3'd7)) w_tx_state_nxt = c_st_stop;
            end
            c_st_stop:  if (w_tx_bit_end) w_tx_state_nxt = c_st_idle;
            default:    w_tx_state_nxt = c_st_idle;
        endcase
        if (r_soft_rst) w_tx_state_nxt = c_st_idle;
    end

    assign txd = w_txd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state   <= c_st_idle;
            r_tx_cnt     <= '0;
            r_tx_bit     <= '0;
            r_tx_shift   <= '0;
            r_write_wait <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            if (r_soft_rst) begin
                r_write_wait <= 1'b0;
                r_tx_cnt     <= '0;
                r_tx_bit     <= '0;
            end else begin
                if (w_tx_accept) begin
                    r_tx_shift   <= data_in[7:0];
                    r_write_wait <= 1'b1;
                end
                if ((r_tx_state == c_st_stop) && w_tx_bit_end) r_write_wait <= 1'b0;
                if ((r_tx_state == c_st_idle) || w_tx_bit_end) r_tx_cnt <= '0;
                else                                           r_tx_cnt <= w_tx_cnt_inc[DIV_W-1:0];
                if (r_tx_state == c_st_idle) r_tx_bit <= '0;
                if ((r_tx_state == c_st_data) && w_tx_bit_end) begin
                    r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                    r_tx_bit   <= r_tx_bit + 3'd1;
                end
            end
        end
    end

    assign w_rx_fall    = r_rx_sync[2] & ~r_rx_sync[1];
    assign w_rx_done    = (r_rx_state == c_st_stop) & w_rx_bit_end & ~r_soft_rst;
    assign w_rx_cnt_clr = (r_rx_state == c_st_idle) | (w_rx_state_nxt != r_rx_state) | w_rx_bit_end;

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        case (r_rx_state)
            c_st_idle:  if (r_rxen && w_rx_fall) w_rx_state_nxt = c_st_start;
            // A start bit found high at its midpoint was a glitch.
            c_st_start: if (w_rx_half_end) w_rx_state_nxt = r_rx_sync[1] ? c_st_idle : c_st_data;
            c_st_data:  if (w_rx_bit_end && (r_rx_bit == 3'd7)) w_rx_state_nxt = c_st_stop;
            c_st_stop:  if (w_rx_bit_end) w_rx_state_nxt = c_st_idle;
            default:    w_rx_state_nxt = c_st_idle;
        endcase
        if (r_soft_rst) w_rx_state_nxt = c_st_idle;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= c_st_idle;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_sync  <= 3'b111;
        end else begin
            r_rx_sync  <= {r_rx_sync[1:0], rxd};
            r_rx_state <= w_rx_state_nxt;
            if (w_rx_cnt_clr) r_rx_cnt <= '0;
            else              r_rx_cnt <= w_rx_cnt_inc[DIV_W-1:0];
            if (r_rx_state == c_st_idle) r_rx_bit <= '0;
            if ((r_rx_state == c_st_data) && w_rx_bit_end) begin
                r_rx_shift <= {r_rx_sync[1], r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 3'd1;
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (address)
            c_addr_write_wait: w_rd_data[0]   = r_write_wait;
            c_addr_data:       w_rd_data[7:0] = r_rx_byte;
            c_addr_read_valid: w_rd_data[0]   = r_rx_valid;
            default:           w_rd_data      = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div      <= '0;
            r_rxen     <= 1'b0;
            r_soft_rst <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_byte  <= '0;
            data_out   <= '0;
        end else begin
            if (w_wr && (address == c_addr_div))        r_div      <= data_in[DIV_W-1:0];
            if (w_wr && (address == c_addr_soft_reset)) r_soft_rst <= data_in[0];
            if (r_soft_rst)                             r_rxen     <= 1'b0;
            else if (w_wr && (address == c_addr_rxen))  r_rxen     <= data_in[0];
            // A byte landing on the same edge as a DATA read keeps the flag set.
            if (r_soft_rst)     r_rx_valid <= 1'b0;
            else if (w_rx_done) r_rx_valid <= 1'b1;
            else if (w_data_rd) r_rx_valid <= 1'b0;
            if (w_rx_done) r_rx_byte <= r_rx_shift;
            if (w_rd)      data_out  <= w_rd_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_regif_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_regif_core
// Brief    : Directed/randomized bench for uart_regif_core against a frame-level
//            reference model; follows UART_HW_FLOW_CTRL_EN like the design.
// Revision : 1.0
// ============================================================================
module tb_uart_regif_core;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;
    localparam int DIV_W  = 16;

    localparam logic [ADDR_W-1:0] c_a_ww    = 3'd0;
    localparam logic [ADDR_W-1:0] c_a_div   = 3'd1;
    localparam logic [ADDR_W-1:0] c_a_data  = 3'd2;
    localparam logic [ADDR_W-1:0] c_a_soft  = 3'd3;
    localparam logic [ADDR_W-1:0] c_a_valid = 3'd4;
    localparam logic [ADDR_W-1:0] c_a_rxen  = 3'd5;

`ifdef UART_HW_FLOW_CTRL_EN
    localparam logic c_flow = 1'b1;
`else
    localparam logic c_flow = 1'b0;
`endif

    logic              clk     = 1'b0;
    logic              rst     = 1'b1;
    logic              sel     = 1'b0;
    logic              write   = 1'b0;
    logic              read    = 1'b0;
    logic [ADDR_W-1:0] address = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic [DATA_W-1:0] data_out;
    logic              txd;
    logic              rxd;
    logic              rts;
    logic              cts     = 1'b1;
    logic              r_loop  = 1'b0;
    logic              r_rxd_drv = 1'b1;

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;

    logic        m_rxen     = 1'b0;
    logic        m_soft     = 1'b0;
    logic        m_rx_valid = 1'b0;
    logic [7:0]  m_rx_byte  = 8'd0;
    int unsigned m_div      = 0;

    assign rxd = r_loop ? txd : r_rxd_drv;

    uart_regif_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst(rst), .sel(sel), .address(address), .write(write), .read(read),
        .data_in(data_in), .data_out(data_out), .txd(txd), .rxd(rxd), .rts(rts), .cts(cts)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run did not complete, cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // Line level expected during bit k of a frame: start, 8 data LSB first, stop.
    function automatic logic exp_txd(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 1 && k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    function automatic logic exp_rts();
        return m_rxen & ~m_soft & (~m_rx_valid | ~c_flow);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int unsigned t);
        while (cyc < t) tick();
    endtask

    task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        sel = 1'b1; write = 1'b1; address = a; data_in = d;
        tick();
        sel = 1'b0; write = 1'b0; data_in = '0;
    endtask

    task automatic bus_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
        sel = 1'b1; read = 1'b1; address = a;
        tick();
        sel = 1'b0; read = 1'b0;
        d = data_out;
    endtask

    task automatic read_check(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        logic [DATA_W-1:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    // Samples the middle of every bit whose midpoint is still ahead of now.
    task automatic check_frame(input string tag, input logic [7:0] b,
                               input int unsigned t_start, input int unsigned div);
        for (int k = 0; k < 10; k++) begin
            int unsigned target;
            target = t_start + div * k + div / 2;
            if (target >= cyc) begin
                wait_until(target);
                check($sformatf("%s_bit%0d", tag, k), 32'(txd), 32'(exp_txd(b, k)));
            end
        end
    endtask

    task automatic loop_byte(input string tag, input logic [7:0] b);
        int unsigned t0;
        bus_write(c_a_data, {24'd0, b});
        t0 = cyc;
        check_frame(tag, b, t0, m_div);
        wait_until(t0 + 11 * m_div + 8);
        m_rx_byte  = b;
        m_rx_valid = 1'b1;
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        int unsigned t0;
        int unsigned t_start;
        logic [7:0] b;

        repeat (3) tick();
        rst = 1'b0;
        check("rst_data_out", data_out, 32'd0);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_rts", 32'(rts), 32'(exp_rts()));
        read_check("rst_ww", c_a_ww, 32'd0);
        read_check("rst_valid", c_a_valid, 32'd0);

        bus_write(c_a_soft, 32'd1); m_soft = 1'b1;
        bus_write(c_a_soft, 32'd0); m_soft = 1'b0;
        bus_write(c_a_div, 32'd16); m_div = 16;
        bus_write(c_a_rxen, 32'd1); m_rxen = 1'b1;
        check("rts_on", 32'(rts), 32'(exp_rts()));

        // Plain TX frame and WRITE_WAIT timing
        bus_write(c_a_data, 32'h55);
        t0 = cyc;
        check_frame("tx55", 8'h55, t0, 16);
        read_check("ww_busy", c_a_ww, 32'd1);
        wait_until(t0 + 162);
        read_check("ww_done", c_a_ww, 32'd0);

        // Loopback receive
        r_loop = 1'b1;
        bus_write(c_a_data, 32'hA3);
        t0 = cyc;
        wait_until(t0 + 100);
        check("rts_rx_mid", 32'(rts), 32'(exp_rts()));
        read_check("valid_mid", c_a_valid, 32'(m_rx_valid));
        check_frame("txA3", 8'hA3, t0, 16);
        wait_until(t0 + 11 * 16 + 8);
        m_rx_byte = 8'hA3; m_rx_valid = 1'b1;
        check("rts_pending", 32'(rts), 32'(exp_rts()));
        read_check("valid_A3", c_a_valid, 32'(m_rx_valid));
        read_check("data_A3", c_a_data, {24'd0, m_rx_byte});
        m_rx_valid = 1'b0;
        read_check("valid_clr", c_a_valid, 32'(m_rx_valid));
        check("rts_after_rd", 32'(rts), 32'(exp_rts()));

        // CTS gating (only holds the frame back in the flow-control build)
        r_loop = 1'b0;
        cts = 1'b0;
        b = 8'h41;
        bus_write(c_a_data, {24'd0, b});
        t0 = cyc;
        wait_until(t0 + 8);
        check("cts_hold0", 32'(txd), 32'(c_flow ? 1'b1 : exp_txd(b, 0)));
        wait_until(t0 + 40);
        check("cts_hold2", 32'(txd), 32'(c_flow ? 1'b1 : exp_txd(b, 2)));
        read_check("cts_ww", c_a_ww, 32'd1);
        wait_until(t0 + 60);
        cts = 1'b1;
        t_start = c_flow ? cyc + 1 : t0;
        check_frame("tx41", b, t_start, 16);
        wait_until(t_start + 16 * 10 + 4);
        read_check("cts_ww_done", c_a_ww, 32'd0);

        // Randomized loopback bytes at random dividers
        r_loop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            m_div = $urandom_range(24, 8);
            bus_write(c_a_div, 32'(m_div));
            b = 8'($urandom);
            loop_byte($sformatf("rnd%0d", i), b);
            read_check("rnd_valid", c_a_valid, 32'(m_rx_valid));
            check("rnd_rts", 32'(rts), 32'(exp_rts()));
            read_check("rnd_data", c_a_data, {24'd0, m_rx_byte});
            m_rx_valid = 1'b0;
            read_check("rnd_valid_clr", c_a_valid, 32'(m_rx_valid));
        end

        // Overrun overwrites the holding register
        bus_write(c_a_div, 32'd16); m_div = 16;
        loop_byte("ovr11", 8'h11);
        loop_byte("ovr22", 8'h22);
        read_check("ovr_data", c_a_data, {24'd0, m_rx_byte});
        m_rx_valid = 1'b0;
        read_check("ovr_valid", c_a_valid, 32'(m_rx_valid));

        // A DATA write while busy is dropped
        bus_write(c_a_data, 32'h33);
        t0 = cyc;
        wait_until(t0 + 20);
        bus_write(c_a_data, 32'h44);
        check_frame("tx33", 8'h33, t0, 16);
        wait_until(t0 + 11 * 16 + 8);
        m_rx_byte = 8'h33; m_rx_valid = 1'b1;
        wait_until(t0 + 400);
        read_check("busy_valid", c_a_valid, 32'(m_rx_valid));
        read_check("busy_data", c_a_data, {24'd0, m_rx_byte});
        m_rx_valid = 1'b0;

        // Soft reset mid-frame with a byte pending; divider survives
        bus_write(c_a_div, 32'd12); m_div = 12;
        loop_byte("pre9C", 8'h9C);
        bus_write(c_a_data, 32'h5A);
        t0 = cyc;
        wait_until(t0 + 40);
        bus_write(c_a_soft, 32'd1);
        m_soft = 1'b1; m_rxen = 1'b0; m_rx_valid = 1'b0;
        tick();
        check("soft_txd", 32'(txd), 32'd1);
        check("soft_rts", 32'(rts), 32'(exp_rts()));
        read_check("soft_ww", c_a_ww, 32'd0);
        read_check("soft_valid", c_a_valid, 32'(m_rx_valid));
        bus_write(c_a_soft, 32'd0); m_soft = 1'b0;
        check("soft_rxen_clr", 32'(rts), 32'(exp_rts()));
        bus_write(c_a_rxen, 32'd1); m_rxen = 1'b1;
        check("soft_rts_back", 32'(rts), 32'(exp_rts()));
        loop_byte("postC6", 8'hC6);
        read_check("post_data", c_a_data, {24'd0, m_rx_byte});
        m_rx_valid = 1'b0;

        // Start-bit glitch is rejected
        r_loop = 1'b0;
        r_rxd_drv = 1'b0;
        repeat (4) tick();
        r_rxd_drv = 1'b1;
        repeat (200) tick();
        read_check("glitch_valid", c_a_valid, 32'(m_rx_valid));

        // Reserved addresses
        bus_write(3'd6, $urandom);
        bus_write(3'd7, $urandom);
        read_check("rsv6", 3'd6, 32'd0);
        read_check("rsv7", 3'd7, 32'd0);
        read_check("rx_byte_hold", c_a_data, {24'd0, m_rx_byte});

        // Hard reset mid-frame
        bus_write(c_a_data, 32'hE7);
        t0 = cyc;
        wait_until(t0 + 30);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_rxen = 1'b0; m_rx_valid = 1'b0; m_rx_byte = 8'd0; m_div = 0; m_soft = 1'b0;
        check("hrst_data_out", data_out, 32'd0);
        check("hrst_txd", 32'(txd), 32'd1);
        check("hrst_rts", 32'(rts), 32'(exp_rts()));
        read_check("hrst_ww", c_a_ww, 32'd0);
        read_check("hrst_valid", c_a_valid, 32'(m_rx_valid));
        read_check("hrst_data", c_a_data, {24'd0, m_rx_byte});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
